// File: rtl/step_sequencer.sv
// Instruction step sequencer: generates fetch/execute/interrupt-entry step numbers,
// arbitrates interrupts and halt at instruction boundaries, and counts retired instructions.
module step_sequencer #(
   parameter int unsigned IRQ_NUM = 4,
   parameter int unsigned STEP_W  = 4,
   parameter int unsigned CNT_W   = 32
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Stop,
   input  logic               Resume,
   input  logic [4:0]         Opcode,
   input  logic [IRQ_NUM-1:0] Irq,
   input  logic [IRQ_NUM-1:0] IrqMask,
   input  logic               IntEn,
   output logic [STEP_W-1:0]  Step,
   output logic               Run,
   output logic               ClearSig,
   output logic               IntCycle,
   output logic [IRQ_NUM-1:0] IntAck,
   output logic [3:0]         IntId,
   output logic [CNT_W-1:0]   Retired
);

   typedef enum logic [2:0] {S_CLEAR, S_FETCH, S_EXEC, S_INT, S_HALT} state_t;

   localparam logic [4:0] OP_HALT = 5'b11011;

   state_t             state;
   logic               stop_latch;
   logic [STEP_W-1:0]  last_step;
   logic [IRQ_NUM-1:0] pending;
   logic [IRQ_NUM-1:0] irq_sel;
   logic [3:0]         irq_idx;
   logic               irq_hit;
   logic               at_boundary;
   logic               halt_req;

   always_comb begin
      last_step = STEP_W'(3);
      case (Opcode) inside
         5'd0, 5'd2:                       last_step = STEP_W'(7);
         5'd15, 5'd16, 5'd19:              last_step = STEP_W'(6);
         5'd1, [5'd3:5'd14], 5'd17, 5'd18,
         5'd20:                            last_step = STEP_W'(5);
         default:                          last_step = STEP_W'(3);
      endcase
   end

   // Lowest set bit of the pending vector picks the serviced line.
   always_comb begin
      pending = Irq & IrqMask;
      irq_hit = IntEn && (|pending);
      irq_sel = pending & (~pending + IRQ_NUM'(1));
      irq_idx = '0;
      for (int unsigned i = 0; i < IRQ_NUM; i++) begin
         if (irq_sel[i]) irq_idx = 4'(i);
      end
   end

   always_comb begin
      at_boundary = ((state == S_EXEC) && (Step == last_step)) ||
                    ((state == S_INT)  && (Step == STEP_W'(2)));
      halt_req    = stop_latch || Stop || ((state == S_EXEC) && (Opcode == OP_HALT));
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state      <= S_CLEAR;
         Step       <= '0;
         Run        <= 1'b0;
         ClearSig   <= 1'b1;
         IntCycle   <= 1'b0;
         IntAck     <= '0;
         IntId      <= '0;
         Retired    <= '0;
         stop_latch <= 1'b0;
      end else begin
         IntAck     <= '0;
         stop_latch <= stop_latch | Stop;
         case (state)
            S_CLEAR: begin
               state    <= S_FETCH;
               Step     <= '0;
               Run      <= 1'b1;
               ClearSig <= 1'b0;
            end
            S_FETCH: begin
               Step <= Step + STEP_W'(1);
               if (Step == STEP_W'(2)) state <= S_EXEC;
            end
            S_EXEC, S_INT: begin
               if ((state == S_EXEC) && at_boundary) Retired <= Retired + CNT_W'(1);
               if (!at_boundary) begin
                  Step <= Step + STEP_W'(1);
               end else if (irq_hit) begin
                  // A pending halt (stop or halt opcode) is carried across the INT sequence.
                  state      <= S_INT;
                  Step       <= '0;
                  IntCycle   <= 1'b1;
                  IntAck     <= irq_sel;
                  IntId      <= irq_idx;
                  stop_latch <= halt_req;
               end else if (halt_req) begin
                  state      <= S_HALT;
                  Step       <= '0;
                  Run        <= 1'b0;
                  IntCycle   <= 1'b0;
                  stop_latch <= 1'b0;
               end else begin
                  state    <= S_FETCH;
                  Step     <= '0;
                  IntCycle <= 1'b0;
               end
            end
            S_HALT: begin
               // Stop seen while already halted is absorbed by the halt itself.
               stop_latch <= 1'b0;
               if (Resume && !Stop) begin
                  state <= S_FETCH;
                  Step  <= '0;
                  Run   <= 1'b1;
               end
            end
            default: state <= S_CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed self-checking bench for step_sequencer: each task drives one scenario
// and compares registered outputs one time unit after the rising edge.
module tb_step_sequencer;

   logic        Clock;
   logic        Reset;
   logic        Stop;
   logic        Resume;
   logic [4:0]  Opcode;
   logic [3:0]  Irq;
   logic [3:0]  IrqMask;
   logic        IntEn;
   logic [3:0]  Step;
   logic        Run;
   logic        ClearSig;
   logic        IntCycle;
   logic [3:0]  IntAck;
   logic [3:0]  IntId;
   logic [31:0] Retired;

   int checks = 0;
   int errors = 0;

   step_sequencer #(.IRQ_NUM(4), .STEP_W(4), .CNT_W(32)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Stop     (Stop),
      .Resume   (Resume),
      .Opcode   (Opcode),
      .Irq      (Irq),
      .IrqMask  (IrqMask),
      .IntEn    (IntEn),
      .Step     (Step),
      .Run      (Run),
      .ClearSig (ClearSig),
      .IntCycle (IntCycle),
      .IntAck   (IntAck),
      .IntId    (IntId),
      .Retired  (Retired)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset;
      Reset = 1'b0; Stop = 1'b0; Resume = 1'b0; Opcode = 5'b00000;
      Irq = 4'b0000; IrqMask = 4'b1111; IntEn = 1'b0;
      tick; tick;
      checks++; if (Step !== 4'd0) begin errors++; $display("FAIL reset_step got %0d exp 0", Step); end
      checks++; if (Run !== 1'b0) begin errors++; $display("FAIL reset_run got %0b exp 0", Run); end
      checks++; if (ClearSig !== 1'b1) begin errors++; $display("FAIL reset_clear got %0b exp 1", ClearSig); end
      checks++; if (IntCycle !== 1'b0) begin errors++; $display("FAIL reset_intcycle got %0b exp 0", IntCycle); end
      checks++; if (IntAck !== 4'b0000) begin errors++; $display("FAIL reset_intack got %b exp 0000", IntAck); end
      checks++; if (IntId !== 4'd0) begin errors++; $display("FAIL reset_intid got %0d exp 0", IntId); end
      checks++; if (Retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %0d exp 0", Retired); end
      Opcode = 5'b00011;
      Reset  = 1'b1;
      tick;
      checks++; if (Step !== 4'd0 || Run !== 1'b1 || ClearSig !== 1'b0) begin
         errors++; $display("FAIL release_t0 got step=%0d run=%0b clr=%0b exp step=0 run=1 clr=0", Step, Run, ClearSig);
      end
   endtask

   task automatic test_add;
      for (int i = 1; i <= 5; i++) begin
         tick;
         checks++; if (Step !== 4'(i) || Run !== 1'b1) begin
            errors++; $display("FAIL add_step got step=%0d run=%0b exp step=%0d run=1", Step, Run, i);
         end
      end
      checks++; if (Retired !== 32'd0) begin errors++; $display("FAIL add_retired_before got %0d exp 0", Retired); end
      tick;
      checks++; if (Step !== 4'd0) begin errors++; $display("FAIL add_wrap_step got %0d exp 0", Step); end
      checks++; if (Retired !== 32'd1) begin errors++; $display("FAIL add_retired got %0d exp 1", Retired); end
   endtask

   task automatic test_ld_jr;
      Opcode = 5'b00000;
      for (int i = 1; i <= 7; i++) begin
         tick;
         checks++; if (Step !== 4'(i)) begin errors++; $display("FAIL ld_step got %0d exp %0d", Step, i); end
      end
      tick;
      checks++; if (Step !== 4'd0 || Retired !== 32'd2) begin
         errors++; $display("FAIL ld_end got step=%0d ret=%0d exp step=0 ret=2", Step, Retired);
      end
      Opcode = 5'b10101;
      tick; tick; tick;
      checks++; if (Step !== 4'd3) begin errors++; $display("FAIL jr_last got %0d exp 3", Step); end
      tick;
      checks++; if (Step !== 4'd0 || Retired !== 32'd3) begin
         errors++; $display("FAIL jr_end got step=%0d ret=%0d exp step=0 ret=3", Step, Retired);
      end
   endtask

   task automatic test_irq;
      Opcode = 5'b00011; IntEn = 1'b1; IrqMask = 4'b1111;
      tick; tick;
      Irq = 4'b0110;
      tick; tick; tick;
      checks++; if (Step !== 4'd5 || IntCycle !== 1'b0) begin
         errors++; $display("FAIL irq_pre got step=%0d ic=%0b exp step=5 ic=0", Step, IntCycle);
      end
      tick;
      checks++; if (IntCycle !== 1'b1 || Step !== 4'd0) begin
         errors++; $display("FAIL irq_i0 got ic=%0b step=%0d exp ic=1 step=0", IntCycle, Step);
      end
      checks++; if (IntAck !== 4'b0010) begin errors++; $display("FAIL irq_ack_i0 got %b exp 0010", IntAck); end
      checks++; if (IntId !== 4'd1) begin errors++; $display("FAIL irq_id got %0d exp 1", IntId); end
      checks++; if (Retired !== 32'd4) begin errors++; $display("FAIL irq_retired got %0d exp 4", Retired); end
      Irq = 4'b0000;
      tick;
      checks++; if (IntCycle !== 1'b1 || Step !== 4'd1 || IntAck !== 4'b0000) begin
         errors++; $display("FAIL irq_i1 got ic=%0b step=%0d ack=%b exp ic=1 step=1 ack=0000", IntCycle, Step, IntAck);
      end
      tick;
      checks++; if (IntCycle !== 1'b1 || Step !== 4'd2 || IntAck !== 4'b0000) begin
         errors++; $display("FAIL irq_i2 got ic=%0b step=%0d ack=%b exp ic=1 step=2 ack=0000", IntCycle, Step, IntAck);
      end
      tick;
      checks++; if (IntCycle !== 1'b0 || Step !== 4'd0 || Retired !== 32'd4 || IntId !== 4'd1) begin
         errors++; $display("FAIL irq_exit got ic=%0b step=%0d ret=%0d id=%0d exp ic=0 step=0 ret=4 id=1",
                            IntCycle, Step, Retired, IntId);
      end
   endtask

   // Line 2 withdrawn before the boundary, line 0 masked at the boundary: no INT.
   task automatic test_irq_drop;
      Opcode = 5'b00011;
      tick;
      Irq = 4'b0100;
      tick; tick;
      Irq = 4'b0001; IrqMask = 4'b1110;
      tick; tick; tick;
      checks++; if (IntCycle !== 1'b0 || Step !== 4'd0 || Retired !== 32'd5 || IntId !== 4'd1) begin
         errors++; $display("FAIL irq_drop got ic=%0b step=%0d ret=%0d id=%0d exp ic=0 step=0 ret=5 id=1",
                            IntCycle, Step, Retired, IntId);
      end
      Irq = 4'b0000; IrqMask = 4'b1111;
   endtask

   task automatic test_nop;
      Opcode = 5'b11010;
      tick; tick; tick;
      checks++; if (Step !== 4'd3) begin errors++; $display("FAIL nop_last got %0d exp 3", Step); end
      tick;
      checks++; if (Step !== 4'd0 || Retired !== 32'd6 || Run !== 1'b1) begin
         errors++; $display("FAIL nop_end got step=%0d ret=%0d run=%0b exp step=0 ret=6 run=1", Step, Retired, Run);
      end
   endtask

   task automatic test_stop;
      Opcode = 5'b10000;
      tick; tick; tick; tick;
      Stop = 1'b1;
      tick;
      Stop = 1'b0;
      checks++; if (Step !== 4'd5 || Run !== 1'b1) begin
         errors++; $display("FAIL stop_mid got step=%0d run=%0b exp step=5 run=1", Step, Run);
      end
      tick;
      checks++; if (Step !== 4'd6 || Run !== 1'b1) begin
         errors++; $display("FAIL stop_t6 got step=%0d run=%0b exp step=6 run=1", Step, Run);
      end
      tick;
      checks++; if (Run !== 1'b0 || Retired !== 32'd7) begin
         errors++; $display("FAIL stop_halt got run=%0b ret=%0d exp run=0 ret=7", Run, Retired);
      end
      for (int i = 0; i < 4; i++) begin
         tick;
         checks++; if (Run !== 1'b0) begin errors++; $display("FAIL halt_hold got run=%0b exp 0", Run); end
      end
      Stop = 1'b1; Resume = 1'b1;
      tick;
      checks++; if (Run !== 1'b0) begin errors++; $display("FAIL stop_over_resume got run=%0b exp 0", Run); end
      Stop = 1'b0;
      tick;
      Resume = 1'b0;
      checks++; if (Run !== 1'b1 || Step !== 4'd0) begin
         errors++; $display("FAIL resume got run=%0b step=%0d exp run=1 step=0", Run, Step);
      end
   endtask

   task automatic test_stop_irq;
      Opcode = 5'b10101;
      tick; tick; tick;
      Stop = 1'b1; Irq = 4'b1000;
      tick;
      Stop = 1'b0; Irq = 4'b0000;
      checks++; if (IntCycle !== 1'b1 || IntAck !== 4'b1000 || IntId !== 4'd3) begin
         errors++; $display("FAIL stopirq_i0 got ic=%0b ack=%b id=%0d exp ic=1 ack=1000 id=3", IntCycle, IntAck, IntId);
      end
      checks++; if (Retired !== 32'd8 || Run !== 1'b1) begin
         errors++; $display("FAIL stopirq_ret got ret=%0d run=%0b exp ret=8 run=1", Retired, Run);
      end
      tick; tick;
      checks++; if (Step !== 4'd2 || IntCycle !== 1'b1) begin
         errors++; $display("FAIL stopirq_i2 got step=%0d ic=%0b exp step=2 ic=1", Step, IntCycle);
      end
      tick;
      checks++; if (Run !== 1'b0 || IntCycle !== 1'b0 || Retired !== 32'd8) begin
         errors++; $display("FAIL stopirq_halt got run=%0b ic=%0b ret=%0d exp run=0 ic=0 ret=8", Run, IntCycle, Retired);
      end
      Resume = 1'b1;
      tick;
      Resume = 1'b0;
      checks++; if (Run !== 1'b1 || Step !== 4'd0) begin
         errors++; $display("FAIL stopirq_resume got run=%0b step=%0d exp run=1 step=0", Run, Step);
      end
   endtask

   task automatic test_async_reset;
      Opcode = 5'b11100;
      tick; tick; tick; tick;
      checks++; if (Retired !== 32'd9) begin errors++; $display("FAIL pre_reset_ret got %0d exp 9", Retired); end
      Opcode = 5'b00000;
      tick; tick; tick; tick;
      checks++; if (Step !== 4'd4) begin errors++; $display("FAIL ld_t4 got %0d exp 4", Step); end
      #2 Reset = 1'b0;
      #1;
      checks++; if (Step !== 4'd0 || Run !== 1'b0 || ClearSig !== 1'b1) begin
         errors++; $display("FAIL async_clear got step=%0d run=%0b clr=%0b exp step=0 run=0 clr=1", Step, Run, ClearSig);
      end
      checks++; if (Retired !== 32'd0 || IntId !== 4'd0 || IntCycle !== 1'b0) begin
         errors++; $display("FAIL async_regs got ret=%0d id=%0d ic=%0b exp ret=0 id=0 ic=0", Retired, IntId, IntCycle);
      end
      Opcode = 5'b11011;
      tick;
      checks++; if (ClearSig !== 1'b1) begin errors++; $display("FAIL held_clear got %0b exp 1", ClearSig); end
      Reset = 1'b1;
      tick;
      checks++; if (Run !== 1'b1 || ClearSig !== 1'b0 || Step !== 4'd0) begin
         errors++; $display("FAIL post_reset_t0 got run=%0b clr=%0b step=%0d exp run=1 clr=0 step=0", Run, ClearSig, Step);
      end
      tick; tick; tick;
      checks++; if (Step !== 4'd3 || Run !== 1'b1) begin
         errors++; $display("FAIL halt_op_t3 got step=%0d run=%0b exp step=3 run=1", Step, Run);
      end
      tick;
      checks++; if (Run !== 1'b0 || Retired !== 32'd1) begin
         errors++; $display("FAIL halt_op got run=%0b ret=%0d exp run=0 ret=1", Run, Retired);
      end
   endtask

   initial begin
      test_reset;
      test_add;
      test_ld_jr;
      test_irq;
      test_irq_drop;
      test_nop;
      test_stop;
      test_stop_irq;
      test_async_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
